tms5200_lattice_seq: RTL and testbench
======================================

TMS5200_LATTICE_SEQ -- requirements
Module: tms5200_lattice_seq

Interface
REQ-001 SHALL have parameter NSTAGES, default 10, number of lattice stages / K coefficients.
REQ-002 SHALL have parameter KW, default 10, K coefficient width in bits.
REQ-003 clk  input  1  system clock; one clock; all state SHALL update on posedge clk.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 clk_en  input  1  sequencer tick; state SHALL advance only on clk edges where clk_en=1.
REQ-006 start  input  1  request one sample pass through the lattice.
REQ-007 k_wr  input  1  write strobe into pending coefficient bank.
REQ-008 k_wr_idx  input  4  coefficient index, 0=K1 .. 9=K10.
REQ-009 k_wr_data  input  KW  coefficient value.
REQ-010 commit  input  1  request copy of pending bank to active bank.
REQ-011 ovr_clr  input  1  clear sticky overrun flag.
REQ-012 kin  output  KW  coefficient presented to the K stack.
REQ-013 kstack_en  output  1  shift/recode enable for the K stack.
REQ-014 stage  output  4  index of coefficient currently presented.
REQ-015 busy  output  1  high whenever state is not IDLE.
REQ-016 done  output  1  one-clk pulse at end of pass.
REQ-017 overrun  output  1  sticky: start arrived while busy.

Function
REQ-018 SHALL implement states IDLE, RUN, DRAIN.
REQ-019 IDLE: on clk_en&start edge SHALL go RUN with stage=NSTAGES-1.
REQ-020 RUN: kin SHALL equal active[stage] combinationally; kstack_en SHALL equal clk_en.
REQ-021 RUN: on clk_en edge, stage>0 SHALL decrement; stage==0 SHALL go DRAIN.
REQ-022 DRAIN: lasts exactly one clk_en tick for K-stack recoder latency; kstack_en SHALL be 0; on clk_en edge SHALL go IDLE and assert done for the following clk cycle only.
REQ-023 Outside RUN, kin SHALL be 0 and kstack_en SHALL be 0.
REQ-024 Pass length: exactly NSTAGES kstack_en ticks, K10 first, K1 last.
REQ-025 k_wr SHALL update pending[k_wr_idx] on any clk edge regardless of clk_en or state; idx >= NSTAGES SHALL be ignored.
REQ-026 commit in IDLE SHALL copy pending to active on that edge (no clk_en needed).
REQ-027 commit while busy SHALL set commit_pend; copy SHALL occur on the DRAIN->IDLE edge; active SHALL never change during a pass.
REQ-028 Simultaneous k_wr and commit in IDLE: active SHALL receive the newly written value.
REQ-029 start while busy (clk_en edge) SHALL be ignored and SHALL set overrun; start on the DRAIN->IDLE edge SHALL also count as overrun.
REQ-030 ovr_clr SHALL clear overrun; simultaneous set and clear SHALL leave overrun=1.
REQ-031 start held high SHALL begin a new pass on the first clk_en tick after returning to IDLE.

Reset
REQ-032 reset SHALL force IDLE, stage=0, done=0, overrun=0, commit_pend=0, pending and active banks all 0.
REQ-033 reset mid-pass SHALL abort immediately; no done pulse; kstack_en=0 from the reset edge.

Structure
REQ-034 NSTAGES, KW defaults and state encoding SHALL live in shared package tms5200_pkg.
REQ-035 Pending/active double-buffered bank SHALL be sub-module tms5200_kbank (write port, commit, async read by index).

Verification
REQ-036 Write K1..K10=0x001..0x00A, commit, start with clk_en every 4th clk -> kin sequence 0x00A..0x001 on 10 consecutive kstack_en ticks, done one tick later.
REQ-037 clk_en tied high, start pulse -> busy high 11 clocks, done high exactly 1 clock, stage 9..0.
REQ-038 During pass write K5=0x3FF and commit -> current pass uses old K5; next pass presents 0x3FF at stage 4.
REQ-039 start pulse at RUN stage 5 -> no restart, overrun=1 until ovr_clr; ovr_clr with start-while-busy same cycle -> overrun stays 1.
REQ-040 Assert reset at RUN stage 3 -> busy=0, kstack_en=0, done never pulses, banks read 0.
REQ-041 k_wr_idx=12 with data 0x155, commit -> all active entries unchanged.

Source files
------------

// File: rtl/tms5200_pkg.sv
// Shared constants and state encoding for the TMS5200 lattice coefficient sequencer.
package tms5200_pkg;

    localparam int NSTAGES_DEF = 10;
    localparam int KW_DEF      = 10;
    localparam int IDX_W       = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } seq_state_t;

endpackage

// File: rtl/tms5200_kbank.sv
// Double-buffered K coefficient bank: a pending bank written at any time and an
// active bank that changes only when the copy strobe is asserted.
module tms5200_kbank
    import tms5200_pkg::*;
#(
    parameter int NSTAGES = NSTAGES_DEF,
    parameter int KW      = KW_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_wr,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  logic [KW-1:0]    i_wr_data,
    input  logic             i_copy,
    input  logic [IDX_W-1:0] i_rd_idx,
    output logic [KW-1:0]    o_rd_data
);

    localparam logic [IDX_W:0] NST = (IDX_W+1)'(NSTAGES);

    logic [KW-1:0] r_pending     [NSTAGES];
    logic [KW-1:0] r_active      [NSTAGES];
    logic [KW-1:0] w_pending_nxt [NSTAGES];
    logic          w_wr_ok;
    logic          w_rd_ok;

    assign w_wr_ok = i_wr && ({1'b0, i_wr_idx} < NST);
    assign w_rd_ok = ({1'b0, i_rd_idx} < NST);

    // Pending bank as it will look after this edge, so a same-cycle write is
    // what gets copied into the active bank.
    always_comb begin
        for (int i = 0; i < NSTAGES; i++) begin
            w_pending_nxt[i] = r_pending[i];
            if (w_wr_ok && (i_wr_idx == IDX_W'(i))) begin
                w_pending_nxt[i] = i_wr_data;
            end
        end
    end

    // Bank storage: pending always tracks writes, active only on copy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NSTAGES; i++) begin
                r_pending[i] <= '0;
                r_active[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NSTAGES; i++) begin
                r_pending[i] <= w_pending_nxt[i];
                if (i_copy) begin
                    r_active[i] <= w_pending_nxt[i];
                end
            end
        end
    end

    assign o_rd_data = w_rd_ok ? r_active[i_rd_idx] : '0;

endmodule

// File: rtl/tms5200_lattice_seq.sv
// Lattice pass sequencer: walks the active K bank from K10 down to K1, one
// coefficient per clk_en tick, then spends one tick draining the K-stack recoder.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start on a clk_en tick; commits copy immediately
// ST_RUN   | presenting active[stage] to the K stack, stage counts down
// ST_DRAIN | one tick of recoder latency, then done pulse and back to idle
module tms5200_lattice_seq
    import tms5200_pkg::*;
#(
    parameter int NSTAGES = NSTAGES_DEF,
    parameter int KW      = KW_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_en,
    input  logic             start,
    input  logic             k_wr,
    input  logic [IDX_W-1:0] k_wr_idx,
    input  logic [KW-1:0]    k_wr_data,
    input  logic             commit,
    input  logic             ovr_clr,
    output logic [KW-1:0]    kin,
    output logic             kstack_en,
    output logic [IDX_W-1:0] stage,
    output logic             busy,
    output logic             done,
    output logic             overrun
);

    localparam logic [IDX_W-1:0] LAST_STAGE = IDX_W'(NSTAGES - 1);

    seq_state_t       r_state;
    seq_state_t       w_state_nxt;
    logic [IDX_W-1:0] r_stage;
    logic             r_done;
    logic             r_overrun;
    logic             r_commit_pend;

    logic             w_idle;
    logic             w_run;
    logic             w_drain;
    logic             w_pass_start;
    logic             w_drain_exit;
    logic             w_copy;
    logic             w_ovr_set;
    logic [KW-1:0]    w_k_active;

    assign w_idle       = (r_state == ST_IDLE);
    assign w_run        = (r_state == ST_RUN);
    assign w_drain      = (r_state == ST_DRAIN);
    assign w_pass_start = w_idle & clk_en & start;
    assign w_drain_exit = w_drain & clk_en;
    // Commits seen mid-pass are held and applied on the return to idle so the
    // active bank is stable for the whole pass.
    assign w_copy       = (w_idle & commit) | (w_drain_exit & (commit | r_commit_pend));
    // The DRAIN->IDLE edge is still busy, so a start there is an overrun too.
    assign w_ovr_set    = clk_en & start & ~w_idle;

    tms5200_kbank #(
        .NSTAGES (NSTAGES),
        .KW      (KW)
    ) u_kbank (
        .clk       (clk),
        .reset     (reset),
        .i_wr      (k_wr),
        .i_wr_idx  (k_wr_idx),
        .i_wr_data (k_wr_data),
        .i_copy    (w_copy),
        .i_rd_idx  (r_stage),
        .o_rd_data (w_k_active)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; every transition waits for a clk_en tick.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (clk_en && start)           w_state_nxt = ST_RUN;
            ST_RUN:   if (clk_en && r_stage == '0)   w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (clk_en)                    w_state_nxt = ST_IDLE;
            default:                                 w_state_nxt = ST_IDLE;
        endcase
    end

    // Outputs to the K stack: only RUN presents a coefficient or enables a shift.
    always_comb begin
        busy      = 1'b1;
        kstack_en = 1'b0;
        kin       = '0;
        case (r_state)
            ST_IDLE: busy = 1'b0;
            ST_RUN: begin
                kstack_en = clk_en;
                kin       = w_k_active;
            end
            default: ;
        endcase
    end

    // Stage down-counter, done pulse, sticky overrun and deferred commit flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stage       <= '0;
            r_done        <= 1'b0;
            r_overrun     <= 1'b0;
            r_commit_pend <= 1'b0;
        end else begin
            if (w_pass_start) begin
                r_stage <= LAST_STAGE;
            end else if (w_run && clk_en && r_stage != '0) begin
                r_stage <= r_stage - 1'b1;
            end

            r_done    <= w_drain_exit;
            r_overrun <= w_ovr_set | (r_overrun & ~ovr_clr);

            if (w_copy) begin
                r_commit_pend <= 1'b0;
            end else if (commit && !w_idle) begin
                r_commit_pend <= 1'b1;
            end
        end
    end

    assign stage   = r_stage;
    assign done    = r_done;
    assign overrun = r_overrun;

endmodule

// File: tb/tb_tms5200_lattice_seq.sv
// Bench for the lattice pass sequencer with a bank-level reference model.
module tb_tms5200_lattice_seq;

    localparam int NST = 10;

    logic       clk = 1'b0;
    logic       reset;
    logic       clk_en;
    logic       start;
    logic       k_wr;
    logic [3:0] k_wr_idx;
    logic [9:0] k_wr_data;
    logic       commit;
    logic       ovr_clr;
    logic [9:0] kin;
    logic       kstack_en;
    logic [3:0] stage;
    logic       busy;
    logic       done;
    logic       overrun;

    int checks = 0;
    int errors = 0;

    logic [9:0] m_pend [NST];
    logic [9:0] m_act  [NST];
    logic       m_ovr;

    always #5 clk = ~clk;

    tms5200_lattice_seq #(.NSTAGES(NST), .KW(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .clk_en    (clk_en),
        .start     (start),
        .k_wr      (k_wr),
        .k_wr_idx  (k_wr_idx),
        .k_wr_data (k_wr_data),
        .commit    (commit),
        .ovr_clr   (ovr_clr),
        .kin       (kin),
        .kstack_en (kstack_en),
        .stage     (stage),
        .busy      (busy),
        .done      (done),
        .overrun   (overrun)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < NST; i++) begin
            m_pend[i] = '0;
            m_act[i]  = '0;
        end
        m_ovr = 1'b0;
    endtask

    task automatic model_commit();
        for (int i = 0; i < NST; i++) m_act[i] = m_pend[i];
    endtask

    // Idle-time write, optionally with a commit on the same edge.
    task automatic write_k(input int idx, input logic [9:0] data, input bit with_commit);
        clk_en    = 1'b0;
        k_wr      = 1'b1;
        k_wr_idx  = 4'(idx);
        k_wr_data = data;
        commit    = with_commit;
        cyc();
        k_wr   = 1'b0;
        commit = 1'b0;
        if (idx < NST) m_pend[idx] = data;
        if (with_commit) model_commit();
    endtask

    task automatic do_commit();
        clk_en = 1'b0;
        commit = 1'b1;
        cyc();
        commit = 1'b0;
        model_commit();
    endtask

    task automatic clear_ovr();
        ovr_clr = 1'b1;
        cyc();
        ovr_clr = 1'b0;
        m_ovr   = 1'b0;
        chk("ovr_clr", overrun, 0);
    endtask

    // One full pass with clk_en every 'per' clocks. act: 0 none, 1 write K5 +
    // commit mid-pass, 2 start mid-pass, 3 start + ovr_clr mid-pass.
    task automatic run_pass(input int per, input int act, input string tag);
        logic [9:0] exp_q[$];
        logic [9:0] got_q[$];
        int busy_cnt = 0;
        int done_cnt = 0;
        int last_ks  = -1;
        int done_c   = -1;
        bit acted    = 0;
        bit defer    = 0;
        for (int i = NST - 1; i >= 0; i--) exp_q.push_back(m_act[i]);
        for (int c = 0; c < 11 * per + 3; c++) begin
            clk_en  = ((c % per) == 0);
            start   = (c == 0);
            k_wr    = 1'b0;
            commit  = 1'b0;
            ovr_clr = 1'b0;
            if (act != 0 && !acted && busy && stage == 4'd5 && clk_en) begin
                acted = 1;
                case (act)
                    1: begin
                        k_wr = 1'b1; k_wr_idx = 4'd4; k_wr_data = 10'h3FF; commit = 1'b1;
                        m_pend[4] = 10'h3FF;
                        defer = 1;
                    end
                    2: begin start = 1'b1; m_ovr = 1'b1; end
                    default: begin start = 1'b1; ovr_clr = 1'b1; m_ovr = 1'b1; end
                endcase
            end
            #1;
            if (kstack_en) begin
                chk({tag, " stage"}, stage, 32'(NST - 1 - got_q.size()));
                got_q.push_back(kin);
                last_ks = c;
            end else if (!busy) begin
                chk({tag, " kin idle"}, kin, 0);
            end
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                done_c = c;
            end
            @(posedge clk);
            #1;
        end
        clk_en  = 1'b0;
        start   = 1'b0;
        k_wr    = 1'b0;
        commit  = 1'b0;
        ovr_clr = 1'b0;
        chk({tag, " ticks"}, got_q.size(), NST);
        for (int i = 0; i < NST && i < got_q.size(); i++) begin
            chk({tag, " kin"}, got_q[i], exp_q[i]);
        end
        chk({tag, " busy len"}, busy_cnt, 11 * per);
        chk({tag, " done cnt"}, done_cnt, 1);
        chk({tag, " done time"}, done_c, last_ks + per + 1);
        chk({tag, " overrun"}, overrun, m_ovr);
        if (acted || act == 0) chk({tag, " act hit"}, acted, act != 0);
        if (defer) model_commit();
    endtask

    initial begin
        reset     = 1'b1;
        clk_en    = 1'b0;
        start     = 1'b0;
        k_wr      = 1'b0;
        k_wr_idx  = '0;
        k_wr_data = '0;
        commit    = 1'b0;
        ovr_clr   = 1'b0;
        model_clear();
        repeat (3) cyc();
        reset = 1'b0;
        cyc();
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst overrun", overrun, 0);
        chk("rst stage", stage, 0);
        chk("rst kin", kin, 0);
        chk("rst kstack_en", kstack_en, 0);

        // K1..K10 = 1..10, commit, slow clk_en
        for (int i = 0; i < NST; i++) write_k(i, 10'(i + 1), 1'b0);
        do_commit();
        run_pass(4, 0, "seq_per4");
        run_pass(1, 0, "seq_per1");

        // mid-pass K5 update must wait for the next pass
        run_pass(1, 1, "k5_during");
        run_pass(1, 0, "k5_after");

        // overrun behaviour
        run_pass(2, 2, "ovr_set");
        repeat (3) cyc();
        chk("ovr sticky", overrun, 1);
        clear_ovr();
        run_pass(1, 3, "ovr_setclr");
        clear_ovr();

        // out-of-range index ignored
        write_k(12, 10'h155, 1'b1);
        do_commit();
        run_pass(1, 0, "bad_idx");

        // randomized bank contents; uncommitted writes must not leak into a pass
        for (int n = 0; n < 6; n++) begin
            for (int w = 0; w < 5; w++) begin
                write_k($urandom_range(0, 13), 10'($urandom_range(0, 1023)), 1'($urandom_range(0, 1)));
            end
            do_commit();
            for (int w = 0; w < 3; w++) begin
                write_k($urandom_range(0, 13), 10'($urandom_range(0, 1023)), 1'b0);
            end
            run_pass($urandom_range(1, 3), 0, "rnd");
        end

        // start held high restarts on the first tick back in idle
        clk_en = 1'b1;
        start  = 1'b1;
        for (int c = 0; c < 14; c++) begin
            if (c == 11) chk("hold busy end", busy, 1);
            if (c == 12) begin
                chk("hold gap", busy, 0);
                chk("hold done", done, 1);
                chk("hold ovr", overrun, 1);
            end
            if (c == 13) chk("hold restart", busy, 1);
            cyc();
        end
        start = 1'b0;
        begin
            int n = 0;
            while (!done && n < 30) begin
                cyc();
                n++;
            end
            chk("hold 2nd done", done, 1);
        end
        clk_en = 1'b0;
        cyc();
        clear_ovr();

        // reset in the middle of a pass
        clk_en = 1'b1;
        start  = 1'b1;
        cyc();
        start = 1'b0;
        begin
            int n = 0;
            while (!(busy && stage == 4'd3) && n < 20) begin
                cyc();
                n++;
            end
        end
        chk("rst mid stage", stage, 3);
        reset = 1'b1;
        #1;
        chk("rst mid busy", busy, 0);
        chk("rst mid kstack_en", kstack_en, 0);
        chk("rst mid stage0", stage, 0);
        for (int c = 0; c < 3; c++) begin
            cyc();
            chk("rst mid done", done, 0);
        end
        reset  = 1'b0;
        clk_en = 1'b0;
        model_clear();
        cyc();
        chk("post rst done", done, 0);
        run_pass(2, 0, "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
